// File: rtl/fft_bf_scheduler_pkg.sv
// Shared types and butterfly address arithmetic for the radix-2 DIT FFT scheduler.
// bf_addr() is the single source of the in-place address / twiddle mapping.
package fft_pkg;

  localparam int MAX_LOG2 = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fft_sched_state_t;

  typedef struct packed {
    logic [MAX_LOG2-1:0] addr_a;
    logic [MAX_LOG2-1:0] addr_b;
    logic [MAX_LOG2-1:0] tw;
  } bf_addr_t;

  // The package cannot see the instance parameters, so the transform size is an argument.
  function automatic bf_addr_t bf_addr(input logic [3:0]          n_log2,
                                       input logic [3:0]          s,
                                       input logic [MAX_LOG2-2:0] b);
    logic [MAX_LOG2-1:0] b_ext;
    logic [MAX_LOG2-1:0] span;
    logic [MAX_LOG2-1:0] idx;
    logic [MAX_LOG2-1:0] grp;
    bf_addr_t            res;
    b_ext      = {1'b0, b};
    span       = 12'd1 << s;
    idx        = b_ext & (span - 12'd1);
    grp        = b_ext >> s;
    res.addr_a = (grp << (s + 4'd1)) | idx;
    res.addr_b = res.addr_a + span;
    res.tw     = idx << (n_log2 - 4'd1 - s);
    return res;
  endfunction

endpackage

// File: rtl/fft_bf_scheduler_if.sv
// Butterfly request channel: scheduler (master) presents addresses, datapath (slave) accepts.
interface fft_bf_scheduler_if #(
  parameter int N_LOG2  = 10,
  parameter int TW_ADDR = N_LOG2 - 1
);
  localparam int SW = $clog2(N_LOG2);

  logic                valid;
  logic                ready;
  logic [N_LOG2-1:0]   addr_a;
  logic [N_LOG2-1:0]   addr_b;
  logic [TW_ADDR-1:0]  tw_addr;
  logic [SW-1:0]       stage;
  logic                last;

  modport master (output valid, addr_a, addr_b, tw_addr, stage, last, input ready);
  modport slave  (input valid, addr_a, addr_b, tw_addr, stage, last, output ready);

endinterface

// File: rtl/fft_bf_scheduler.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT with an inter-stage drain gap.
// All outputs are registered from the next-state values, so nothing is combinational from ready/start.
module fft_bf_scheduler
  import fft_pkg::*;
#(
  parameter int N_LOG2  = 10,
  parameter int TW_ADDR = N_LOG2 - 1,
  parameter int BF_LAT  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  fft_bf_scheduler_if.master  bf,
  output logic                busy_o,
  output logic                done_o
);

  localparam int SW = $clog2(N_LOG2);
  localparam int BW = N_LOG2 - 1;
  localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  localparam logic [BW-1:0] LAST_B     = {BW{1'b1}};
  localparam logic [SW-1:0] LAST_S     = SW'(N_LOG2 - 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'((BF_LAT > 0) ? BF_LAT - 1 : 0);

  fft_sched_state_t state_r, state_nxt_s;
  logic [SW-1:0]    stage_r, stage_nxt_s;
  logic [BW-1:0]    bfly_r, bfly_nxt_s;
  logic [DW-1:0]    drain_r, drain_nxt_s;
  logic             fire_s;
  logic             advance_s;
  logic             run_nxt_s;
  bf_addr_t         bf_s;
  logic             bf_unused_s;

  assign fire_s      = (state_r == ST_RUN) && bf.ready;
  assign run_nxt_s   = (state_nxt_s == ST_RUN);
  assign bf_s        = bf_addr(4'(N_LOG2), 4'(stage_nxt_s), (MAX_LOG2-1)'(bfly_nxt_s));
  assign bf_unused_s = ^bf_s;

  // Next-state and counter update; advance_s marks the end of a stage's drain gap.
  always_comb begin
    state_nxt_s = state_r;
    stage_nxt_s = stage_r;
    bfly_nxt_s  = bfly_r;
    drain_nxt_s = drain_r;
    advance_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt_s = ST_RUN;
          stage_nxt_s = SW'(0);
          bfly_nxt_s  = BW'(0);
          drain_nxt_s = DW'(0);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (fire_s && (bfly_r == LAST_B)) begin
          if (BF_LAT == 0) begin
            advance_s = 1'b1;
          end else begin
            state_nxt_s = ST_DRAIN;
            drain_nxt_s = DRAIN_INIT;
          end
        end else if (fire_s) begin
          bfly_nxt_s = bfly_r + BW'(1);
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_r == DW'(0)) begin
          advance_s = 1'b1;
        end else begin
          drain_nxt_s = drain_r - DW'(1);
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        stage_nxt_s = SW'(0);
        bfly_nxt_s  = BW'(0);
        drain_nxt_s = DW'(0);
      end
      default: begin
        state_nxt_s = ST_IDLE;
        stage_nxt_s = SW'(0);
        bfly_nxt_s  = BW'(0);
        drain_nxt_s = DW'(0);
      end
    endcase

    if (advance_s) begin
      bfly_nxt_s = BW'(0);
      if (stage_r == LAST_S) begin
        state_nxt_s = ST_DONE;
      end else begin
        state_nxt_s = ST_RUN;
        stage_nxt_s = stage_r + SW'(1);
      end
    end else begin
      bfly_nxt_s = bfly_nxt_s;
    end
  end

  // FSM and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      stage_r <= SW'(0);
      bfly_r  <= BW'(0);
      drain_r <= DW'(0);
    end else begin
      state_r <= state_nxt_s;
      stage_r <= stage_nxt_s;
      bfly_r  <= bfly_nxt_s;
      drain_r <= drain_nxt_s;
    end
  end

  // Registered outputs; addresses only load when the next cycle presents a butterfly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bf.valid   <= 1'b0;
      bf.last    <= 1'b0;
      bf.addr_a  <= N_LOG2'(0);
      bf.addr_b  <= N_LOG2'(0);
      bf.tw_addr <= TW_ADDR'(0);
      bf.stage   <= SW'(0);
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      bf.valid <= run_nxt_s;
      bf.last  <= run_nxt_s && (bfly_nxt_s == LAST_B);
      busy_o   <= (state_nxt_s != ST_IDLE);
      done_o   <= (state_nxt_s == ST_DONE);
      if (run_nxt_s) begin
        bf.addr_a  <= bf_s.addr_a[N_LOG2-1:0];
        bf.addr_b  <= bf_s.addr_b[N_LOG2-1:0];
        bf.tw_addr <= bf_s.tw[TW_ADDR-1:0];
        bf.stage   <= stage_nxt_s;
      end
    end
  end

endmodule

// File: tb/tb_fft_bf_scheduler.sv
// Randomised self-checking bench: three scheduler configurations checked against a plain
// arithmetic model of the butterfly sequence and the cycle-level stage/drain timeline.
module tb_fft_bf_scheduler;

  typedef struct {
    int a;
    int b;
    int tw;
    int s;
    logic last;
  } bfly_t;

  logic clk;
  logic rst_v   [3];
  logic start_v [3];
  logic ready_v [3];
  logic busy_w  [3];
  logic done_w  [3];

  int n_cmp = 0;
  int n_bad = 0;
  bfly_t exp_q[$];

  int gold_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int gold_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int gold_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  fft_bf_scheduler_if #(.N_LOG2(3),  .TW_ADDR(2)) bf0 ();
  fft_bf_scheduler_if #(.N_LOG2(3),  .TW_ADDR(2)) bf1 ();
  fft_bf_scheduler_if #(.N_LOG2(10), .TW_ADDR(9)) bf2 ();

  assign bf0.ready = ready_v[0];
  assign bf1.ready = ready_v[1];
  assign bf2.ready = ready_v[2];

  fft_bf_scheduler #(.N_LOG2(3), .TW_ADDR(2), .BF_LAT(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_v[0]), .start_i(start_v[0]), .bf(bf0),
    .busy_o(busy_w[0]), .done_o(done_w[0]));
  fft_bf_scheduler #(.N_LOG2(3), .TW_ADDR(2), .BF_LAT(2)) u_dut1 (
    .clk_i(clk), .rst_i(rst_v[1]), .start_i(start_v[1]), .bf(bf1),
    .busy_o(busy_w[1]), .done_o(done_w[1]));
  fft_bf_scheduler #(.N_LOG2(10), .TW_ADDR(9), .BF_LAT(4)) u_dut2 (
    .clk_i(clk), .rst_i(rst_v[2]), .start_i(start_v[2]), .bf(bf2),
    .busy_o(busy_w[2]), .done_o(done_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input int a, input int b, input int tw, input int s,
                                       input logic last);
    return {a[15:0], b[15:0], tw[15:0], s[7:0], 7'd0, last};
  endfunction

  task automatic sample(input int d, output logic v, output logic l, output logic bz,
                        output logic dn, output int a, output int bb, output int tw,
                        output int st);
    case (d)
      0: begin
        v = bf0.valid; l = bf0.last; a = int'(bf0.addr_a); bb = int'(bf0.addr_b);
        tw = int'(bf0.tw_addr); st = int'(bf0.stage);
      end
      1: begin
        v = bf1.valid; l = bf1.last; a = int'(bf1.addr_a); bb = int'(bf1.addr_b);
        tw = int'(bf1.tw_addr); st = int'(bf1.stage);
      end
      default: begin
        v = bf2.valid; l = bf2.last; a = int'(bf2.addr_a); bb = int'(bf2.addr_b);
        tw = int'(bf2.tw_addr); st = int'(bf2.stage);
      end
    endcase
    bz = busy_w[d];
    dn = done_w[d];
  endtask

  // Expected butterfly order straight from the stage/group/index definition.
  task automatic build_model(input int L);
    bfly_t e;
    int half, span;
    exp_q.delete();
    half = 2 ** (L - 1);
    for (int s = 0; s < L; s++) begin
      span = 2 ** s;
      for (int b = 0; b < half; b++) begin
        e.a    = (b / span) * 2 * span + (b % span);
        e.b    = e.a + span;
        e.tw   = (b % span) * (2 ** (L - 1 - s));
        e.s    = s;
        e.last = (b == half - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_xform(input int d, input int L, input int lat, input bit rnd,
                           input bit poke);
    int half, per, total, budget, k, r, a, bb, tw, st;
    bit done_seen, prev_stall, rdy, ev, el, ed;
    logic v, l, bz, dn;
    logic [63:0] last_out;
    bfly_t e;
    half   = 2 ** (L - 1);
    per    = half + lat;
    total  = L * per + 1;
    budget = rnd ? 4 * total + 50 : total + 5;
    build_model(L);
    k = 0; done_seen = 1'b0; prev_stall = 1'b0; last_out = 64'd0;
    ready_v[d] = 1'b1;
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    for (int cyc = 1; cyc <= budget && !done_seen; cyc++) begin
      sample(d, v, l, bz, dn, a, bb, tw, st);
      if (!rnd) begin
        r  = (cyc - 1) % per;
        ev = (cyc < total) && (r < half);
        el = ev && (r == half - 1);
        ed = (cyc == total);
        chk("timing", {60'd0, v, l, dn, bz}, {60'd0, ev, el, ed, 1'b1});
      end
      if (prev_stall) chk("valid_hold", {63'd0, v}, 64'd1);
      if (v) begin
        if (exp_q.size() == 0) begin
          chk("extra_bfly", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q[0];
          chk("bfly", pack(a, bb, tw, st, l), pack(e.a, e.b, e.tw, e.s, e.last));
          chk("a_lt_b", {63'd0, (a < bb)}, 64'd1);
          chk("tw_range", {63'd0, (tw < half)}, 64'd1);
          if (L == 3 && k < 12)
            chk("gold", pack(a, bb, tw, 0, 1'b0), pack(gold_a[k], gold_b[k], gold_tw[k], 0, 1'b0));
        end
      end else if (k > 0) begin
        chk("hold_out", pack(a, bb, tw, st, l), last_out);
      end
      if (dn) begin
        done_seen = 1'b1;
        chk("left_over", 64'(exp_q.size()), 64'd0);
      end
      rdy = rnd ? ($urandom_range(1, 0) == 1) : 1'b1;
      ready_v[d] = rdy;
      if (v && rdy && exp_q.size() > 0) begin
        last_out = pack(exp_q[0].a, exp_q[0].b, exp_q[0].tw, exp_q[0].s, 1'b0);
        void'(exp_q.pop_front());
        k++;
      end
      prev_stall = v && !rdy;
      start_v[d] = poke && (cyc == 3 || dn);
      @(negedge clk);
    end
    chk("finished", {63'd0, done_seen}, 64'd1);
    start_v[d] = 1'b0;
    ready_v[d] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample(d, v, l, bz, dn, a, bb, tw, st);
      chk("post_done", {61'd0, v, bz, dn}, 64'd0);
      @(negedge clk);
    end
  endtask

  task automatic reset_at(input int d, input int n, input logic [1:0] exp_vb);
    int a, bb, tw, st;
    logic v, l, bz, dn;
    ready_v[d] = 1'b1;
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    repeat (n - 1) @(negedge clk);
    sample(d, v, l, bz, dn, a, bb, tw, st);
    chk("rst_pos", {62'd0, v, bz}, {62'd0, exp_vb});
    if (d == 0) chk("rst_pos_bfly", pack(a, bb, tw, st, l), pack(4, 6, 0, 1, 1'b0));
    rst_v[d] = 1'b1;
    @(negedge clk);
    sample(d, v, l, bz, dn, a, bb, tw, st);
    chk("rst_bus", pack(a, bb, tw, st, l), 64'd0);
    chk("rst_ctl", {61'd0, v, bz, dn}, 64'd0);
    rst_v[d] = 1'b0;
  endtask

  initial begin
    int a, bb, tw, st;
    logic v, l, bz, dn;
    for (int i = 0; i < 3; i++) begin
      rst_v[i] = 1'b1; start_v[i] = 1'b0; ready_v[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sample(i, v, l, bz, dn, a, bb, tw, st);
      chk("reset_bus", pack(a, bb, tw, st, l), 64'd0);
      chk("reset_ctl", {61'd0, v, bz, dn}, 64'd0);
      rst_v[i] = 1'b0;
    end
    @(negedge clk);

    run_xform(0, 3, 0, 1'b0, 1'b0);
    run_xform(1, 3, 2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_xform(0, 3, 0, 1'b1, 1'b0);
      run_xform(1, 3, 2, 1'b1, 1'b0);
    end
    reset_at(0, 7, 2'b11);
    run_xform(0, 3, 0, 1'b0, 1'b0);
    reset_at(1, 6, 2'b01);
    run_xform(1, 3, 2, 1'b0, 1'b0);
    run_xform(0, 3, 0, 1'b0, 1'b1);
    run_xform(0, 3, 0, 1'b0, 1'b0);
    run_xform(1, 3, 2, 1'b0, 1'b1);
    run_xform(2, 10, 4, 1'b0, 1'b0);
    run_xform(2, 10, 4, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
